// File: rtl/beat_src.sv
// Valid/ready burst source: emits burst_len incrementing beats from a seed,
// with an optional fixed idle gap after each accepted beat except the last.
module beat_src #(
  parameter int DW  = 3,
  parameter int LW  = 4,
  parameter int GAP = 0
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          start,
  input  logic [LW-1:0] burst_len,
  input  logic [DW-1:0] data_seed,
  input  logic          ready_down,
  output logic          valid_down,
  output logic [DW-1:0] data_down,
  output logic          busy,
  output logic          done
);

  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] sent_q;
  logic [LW-1:0] sent_nx;
  logic [GW-1:0] gap_cnt;

  assign sent_nx = sent_q + LW'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      valid_down <= 1'b0;
      data_down  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      len_q      <= '0;
      sent_q     <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          valid_down <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            if (burst_len != '0) begin
              state      <= S_SEND;
              valid_down <= 1'b1;
              data_down  <= data_seed;
              busy       <= 1'b1;
              len_q      <= burst_len;
              sent_q     <= '0;
            end else begin
              // Empty burst still reports completion, without ever raising busy
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (ready_down) begin
            sent_q <= sent_nx;
            if (sent_nx == len_q) begin
              state      <= S_DONE;
              valid_down <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else if (GAP == 0) begin
              data_down <= data_down + DW'(1);
            end else begin
              state      <= S_GAP;
              valid_down <= 1'b0;
              gap_cnt    <= GW'(GAP);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt <= GW'(1)) begin
            state      <= S_SEND;
            valid_down <= 1'b1;
            data_down  <= data_down + DW'(1);
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_src.sv
// Directed bench for beat_src: one back-to-back instance and one with a 2-cycle gap.
module tb_beat_src;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [3:0] burst_len = '0;
  logic [2:0] data_seed = '0;
  logic       ready_down = 1'b0;
  logic       valid0, valid1, busy0, busy1, done0, done1;
  logic [2:0] data0, data1;

  int n_checks = 0;
  int n_pass = 0;
  int acc[32];
  int nacc, nbusy, ncyc, vpat;
  bit done_seen;

  always #5 sys_clk = ~sys_clk;

  beat_src #(.DW(3), .LW(4), .GAP(0)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start0), .burst_len(burst_len),
    .data_seed(data_seed), .ready_down(ready_down), .valid_down(valid0),
    .data_down(data0), .busy(busy0), .done(done0));

  beat_src #(.DW(3), .LW(4), .GAP(2)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start1), .burst_len(burst_len),
    .data_seed(data_seed), .ready_down(ready_down), .valid_down(valid1),
    .data_down(data1), .busy(busy1), .done(done1));

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // A stalled beat must hold valid and data across the next edge
  bit       prev_stall = 1'b0;
  int       prev_vd = 0;
  always @(negedge sys_clk) begin
    if (sys_rst_n && prev_stall) chk("stall_hold", {28'd0, valid0, data0}, prev_vd);
    prev_stall = sys_rst_n && valid0 && !ready_down;
    prev_vd = {28'd0, valid0, data0};
  end

  // rmode 0: always ready; 1: ready pattern 1,0,0 repeating. mid: cycle of a spurious start.
  task automatic burst(input bit sel, input int len, input int seed, input int rmode,
                       input int mid);
    logic v, b, d;
    logic [2:0] dat;
    burst_len = 4'(len);
    data_seed = 3'(seed);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    nacc = 0; nbusy = 0; ncyc = 0; vpat = 0; done_seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      ready_down = (rmode == 0) ? 1'b1 : (c % 3 == 0);
      if (c > 0) begin
        if (sel) start1 = (c == mid); else start0 = (c == mid);
        if (c == mid) begin
          burst_len = 4'd9;
          data_seed = 3'd5;
        end
      end
      v   = sel ? valid1 : valid0;
      dat = sel ? data1 : data0;
      if (c > 0) vpat = (vpat << 1) | int'(v);
      if (v && ready_down && nacc < 32) begin
        acc[nacc] = int'(dat);
        nacc++;
      end
      tick();
      ncyc++;
      b = sel ? busy1 : busy0;
      d = sel ? done1 : done0;
      if (b) nbusy++;
      if (d) begin
        done_seen = 1'b1;
        break;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    chk("done_seen", int'(done_seen), 1);
  endtask

  task automatic chk_beats(input string tag, input int len, input int seed);
    chk({tag, "_count"}, nacc, len);
    for (int i = 0; i < len && i < nacc; i++) chk({tag, "_beat"}, acc[i], (seed + i) & 7);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_valid", int'(valid0), 0);
    chk("rst_data", int'(data0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    #20 sys_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", int'(valid0), 0);
    end

    // Back-to-back burst
    burst(1'b0, 4, 2, 0, -1);
    chk_beats("b2b", 4, 2);
    chk("b2b_cycles", ncyc, 5);
    chk("b2b_busy", nbusy, 4);
    tick();
    chk("b2b_done_pulse", int'(done0), 0);

    // Backpressure and data wrap
    burst(1'b0, 5, 6, 1, -1);
    chk_beats("bp", 5, 6);
    chk("bp_cycles", ncyc, 16);
    tick();

    // Gap insertion
    burst(1'b1, 3, 4, 0, -1);
    chk_beats("gap", 3, 4);
    chk("gap_pattern", vpat, 7'b1001001);
    chk("gap_cycles", ncyc, 8);
    tick();

    // Zero-length burst
    burst(1'b0, 0, 3, 0, -1);
    chk("zero_cycles", ncyc, 1);
    chk("zero_beats", nacc, 0);
    chk("zero_busy", nbusy, 0);
    tick();

    // Start while busy is ignored
    burst(1'b0, 4, 0, 0, 2);
    chk_beats("midstart", 4, 0);
    tick();
    chk("midstart_idle", int'(valid0), 0);

    // Maximum length
    burst(1'b0, 15, 1, 0, -1);
    chk_beats("max", 15, 1);
    chk("max_cycles", ncyc, 16);
    tick();

    // Reset mid-burst
    burst_len = 4'd6;
    data_seed = 3'd3;
    ready_down = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    chk("pre_rst_data", int'(data0), 5);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(valid0), 0);
    chk("mid_rst_data", int'(data0), 0);
    chk("mid_rst_busy", int'(busy0), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_done", int'(done0), 0);
    end
    #3 sys_rst_n = 1'b1;
    tick();
    chk("post_rst_done", int'(done0), 0);
    burst(1'b0, 6, 3, 0, -1);
    chk_beats("fresh", 6, 3);
    chk("fresh_cycles", ncyc, 7);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
